// File: rtl/cmd_resp_buffer.sv
// rtl/cmd_resp_buffer.sv - command-response packet buffer: zero-pads responses to fixed packets, NUM_PKTS-slot ring
module cmd_resp_buffer #(
    parameter int PKT_WORDS = 256,
    parameter int NUM_PKTS  = 2
) (
    input  logic        txclk,
    input  logic        reset,
    input  logic [15:0] rx_databus,
    input  logic        rx_WR,
    input  logic        rx_WR_done,
    output logic        rx_WR_enabled,
    output logic        pkt_waiting,
    input  logic        RD,
    input  logic        RD_done,
    output logic [15:0] dataout,
    input  logic        clear_status,
    output logic [7:0]  dropped_words
);
    localparam int SLOT_W = $clog2(NUM_PKTS);
    localparam int OFF_W  = $clog2(PKT_WORDS);
    localparam int IDX_W  = OFF_W + 1;
    localparam int CNT_W  = SLOT_W + 1;
    localparam int DEPTH  = PKT_WORDS * NUM_PKTS;

    localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(PKT_WORDS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PKT_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_PKTS);

    typedef enum logic [1:0] {W_IDLE, W_FILL, W_PAD} wstate_t;

    wstate_t              state, state_next;
    logic [SLOT_W-1:0]    wr_slot, rd_slot;
    logic [IDX_W-1:0]     wr_idx, wr_idx_next, rd_idx;
    logic [CNT_W-1:0]     pkt_count;
    logic [15:0]          mem [DEPTH];

    logic                 mem_we, commit, drop, done_eval, rd_fire, release_slot;
    logic [15:0]          mem_wdata;

    assign rx_WR_enabled = !reset && (state != W_PAD) && (pkt_count < CNT_FULL);
    assign pkt_waiting   = (pkt_count != '0);
    assign rd_fire       = RD && pkt_waiting;
    assign release_slot  = pkt_waiting && (RD_done || (RD && rd_idx == IDX_LAST));

    always_ff @(posedge txclk or posedge reset) begin
        if (reset) state <= W_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        wr_idx_next = wr_idx;
        mem_we      = 1'b0;
        mem_wdata   = rx_databus;
        commit      = 1'b0;
        drop        = 1'b0;
        done_eval   = 1'b0;
        case (state)
            W_IDLE: begin
                // A lone done with no data is ignored so empty packets never exist
                if (rx_WR && rx_WR_enabled) begin
                    mem_we      = 1'b1;
                    wr_idx_next = IDX_W'(1);
                    state_next  = W_FILL;
                    done_eval   = rx_WR_done;
                end else if (rx_WR) begin
                    drop = 1'b1;
                end
            end
            W_FILL: begin
                if (rx_WR) begin
                    if (wr_idx != IDX_FULL) begin
                        mem_we      = 1'b1;
                        wr_idx_next = wr_idx + IDX_W'(1);
                    end else begin
                        drop = 1'b1;
                    end
                end
                done_eval = rx_WR_done;
            end
            W_PAD: begin
                mem_we      = 1'b1;
                mem_wdata   = 16'h0000;
                wr_idx_next = wr_idx + IDX_W'(1);
                drop        = rx_WR;
                commit      = (wr_idx == IDX_LAST);
            end
            default: state_next = W_IDLE;
        endcase
        // Done is judged against the index after this cycle's write
        if (done_eval) begin
            if (wr_idx_next == IDX_FULL) commit = 1'b1;
            else                         state_next = W_PAD;
        end
        if (commit) begin
            state_next  = W_IDLE;
            wr_idx_next = '0;
        end
    end

    always_ff @(posedge txclk) begin
        if (mem_we) mem[{wr_slot, wr_idx[OFF_W-1:0]}] <= mem_wdata;
    end

    always_ff @(posedge txclk or posedge reset) begin
        if (reset) begin
            wr_idx        <= '0;
            wr_slot       <= '0;
            rd_idx        <= '0;
            rd_slot       <= '0;
            pkt_count     <= '0;
            dataout       <= 16'h0000;
            dropped_words <= 8'h00;
        end else begin
            wr_idx <= wr_idx_next;
            if (commit) wr_slot <= wr_slot + SLOT_W'(1);

            if (rd_fire) begin
                dataout <= mem[{rd_slot, rd_idx[OFF_W-1:0]}];
                rd_idx  <= rd_idx + IDX_W'(1);
            end
            if (release_slot) begin
                rd_idx  <= '0;
                rd_slot <= rd_slot + SLOT_W'(1);
            end

            case ({commit, release_slot})
                2'b10:   pkt_count <= pkt_count + CNT_W'(1);
                2'b01:   pkt_count <= pkt_count - CNT_W'(1);
                default: pkt_count <= pkt_count;
            endcase

            if (clear_status)                       dropped_words <= 8'h00;
            else if (drop && dropped_words != 8'hFF) dropped_words <= dropped_words + 8'h01;
        end
    end
endmodule

// File: tb/tb_cmd_resp_buffer.sv
// tb/tb_cmd_resp_buffer.sv - directed self-checking bench for cmd_resp_buffer
module tb_cmd_resp_buffer;
    logic        txclk = 1'b0;
    logic        reset;
    logic [15:0] rx_databus;
    logic        rx_WR, rx_WR_done, RD, RD_done, clear_status;
    logic        rx_WR_enabled, pkt_waiting;
    logic [15:0] dataout;
    logic [7:0]  dropped_words;

    int errors = 0;
    int checks = 0;

    cmd_resp_buffer #(.PKT_WORDS(256), .NUM_PKTS(2)) dut (
        .txclk         (txclk),
        .reset         (reset),
        .rx_databus    (rx_databus),
        .rx_WR         (rx_WR),
        .rx_WR_done    (rx_WR_done),
        .rx_WR_enabled (rx_WR_enabled),
        .pkt_waiting   (pkt_waiting),
        .RD            (RD),
        .RD_done       (RD_done),
        .dataout       (dataout),
        .clear_status  (clear_status),
        .dropped_words (dropped_words)
    );

    always #5 txclk = ~txclk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge txclk);
        #1;
    endtask

    task automatic write_word(input logic [15:0] d);
        rx_databus = d;
        rx_WR = 1'b1;
        cyc();
        rx_WR = 1'b0;
    endtask

    task automatic pulse_done();
        rx_WR_done = 1'b1;
        cyc();
        rx_WR_done = 1'b0;
    endtask

    task automatic read_word();
        RD = 1'b1;
        cyc();
        RD = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc();
        checks++; if (rx_WR_enabled !== 1'b0) begin errors++; $display("FAIL rst_en: got %b expected 0", rx_WR_enabled); end
        checks++; if (pkt_waiting !== 1'b0) begin errors++; $display("FAIL rst_waiting: got %b expected 0", pkt_waiting); end
        checks++; if (dataout !== 16'h0000) begin errors++; $display("FAIL rst_dataout: got %h expected 0000", dataout); end
        checks++; if (dropped_words !== 8'h00) begin errors++; $display("FAIL rst_dropped: got %0d expected 0", dropped_words); end
        reset = 1'b0;
        cyc();
        checks++; if (rx_WR_enabled !== 1'b1) begin errors++; $display("FAIL rst_en_after: got %b expected 1", rx_WR_enabled); end
    endtask

    task automatic test_pad_packet();
        for (int i = 1; i <= 4; i++) write_word(16'hA000 + 16'(i));
        pulse_done();
        checks++; if (rx_WR_enabled !== 1'b0) begin errors++; $display("FAIL pad_en_low: got %b expected 0", rx_WR_enabled); end
        repeat (251) cyc();
        checks++; if (pkt_waiting !== 1'b0) begin errors++; $display("FAIL pad_early_waiting: got %b expected 0", pkt_waiting); end
        cyc();
        checks++; if (pkt_waiting !== 1'b1) begin errors++; $display("FAIL pad_waiting: got %b expected 1", pkt_waiting); end
        checks++; if (rx_WR_enabled !== 1'b1) begin errors++; $display("FAIL pad_en_back: got %b expected 1", rx_WR_enabled); end
        for (int i = 0; i < 256; i++) begin
            logic [15:0] exp;
            exp = (i < 4) ? 16'hA001 + 16'(i) : 16'h0000;
            read_word();
            checks++; if (dataout !== exp) begin errors++; $display("FAIL pad_read[%0d]: got %h expected %h", i, dataout, exp); end
            if (i == 254) begin
                checks++; if (pkt_waiting !== 1'b1) begin errors++; $display("FAIL pad_waiting_255: got %b expected 1", pkt_waiting); end
            end
        end
        checks++; if (pkt_waiting !== 1'b0) begin errors++; $display("FAIL pad_release: got %b expected 0", pkt_waiting); end
    endtask

    task automatic test_full_packet();
        for (int i = 0; i < 256; i++) write_word(16'h1000 + 16'(i * 3));
        checks++; if (dropped_words !== 8'd0) begin errors++; $display("FAIL full_no_drop: got %0d expected 0", dropped_words); end
        write_word(16'hDEAD);
        checks++; if (dropped_words !== 8'd1) begin errors++; $display("FAIL full_drop: got %0d expected 1", dropped_words); end
        pulse_done();
        checks++; if (pkt_waiting !== 1'b1) begin errors++; $display("FAIL full_commit: got %b expected 1", pkt_waiting); end
        checks++; if (rx_WR_enabled !== 1'b1) begin errors++; $display("FAIL full_en: got %b expected 1", rx_WR_enabled); end
        for (int i = 0; i < 256; i++) begin
            read_word();
            checks++; if (dataout !== 16'h1000 + 16'(i * 3)) begin errors++; $display("FAIL full_read[%0d]: got %h expected %h", i, dataout, 16'h1000 + 16'(i * 3)); end
        end
        checks++; if (pkt_waiting !== 1'b0) begin errors++; $display("FAIL full_release: got %b expected 0", pkt_waiting); end
        clear_status = 1'b1;
        cyc();
        clear_status = 1'b0;
        checks++; if (dropped_words !== 8'd0) begin errors++; $display("FAIL full_clear: got %0d expected 0", dropped_words); end
    endtask

    task automatic test_backpressure_rd_done();
        for (int i = 0; i < 20; i++) write_word(16'hB000 + 16'(i));
        pulse_done();
        repeat (236) cyc();
        for (int i = 0; i < 20; i++) write_word(16'hC000 + 16'(i));
        pulse_done();
        repeat (236) cyc();
        checks++; if (rx_WR_enabled !== 1'b0) begin errors++; $display("FAIL bp_en_low: got %b expected 0", rx_WR_enabled); end
        repeat (3) write_word(16'h5555);
        checks++; if (dropped_words !== 8'd3) begin errors++; $display("FAIL bp_drop3: got %0d expected 3", dropped_words); end
        rx_WR = 1'b1;
        repeat (300) cyc();
        rx_WR = 1'b0;
        checks++; if (dropped_words !== 8'd255) begin errors++; $display("FAIL bp_saturate: got %0d expected 255", dropped_words); end
        rx_WR = 1'b1;
        clear_status = 1'b1;
        cyc();
        rx_WR = 1'b0;
        clear_status = 1'b0;
        checks++; if (dropped_words !== 8'd0) begin errors++; $display("FAIL bp_clear_prio: got %0d expected 0", dropped_words); end
        for (int i = 0; i < 10; i++) begin
            read_word();
            checks++; if (dataout !== 16'hB000 + 16'(i)) begin errors++; $display("FAIL bp_read[%0d]: got %h expected %h", i, dataout, 16'hB000 + 16'(i)); end
        end
        RD_done = 1'b1;
        cyc();
        RD_done = 1'b0;
        checks++; if (rx_WR_enabled !== 1'b1) begin errors++; $display("FAIL rddone_en: got %b expected 1", rx_WR_enabled); end
        checks++; if (pkt_waiting !== 1'b1) begin errors++; $display("FAIL rddone_waiting: got %b expected 1", pkt_waiting); end
        read_word();
        checks++; if (dataout !== 16'hC000) begin errors++; $display("FAIL rddone_next: got %h expected c000", dataout); end
        RD = 1'b1;
        RD_done = 1'b1;
        cyc();
        RD = 1'b0;
        RD_done = 1'b0;
        checks++; if (dataout !== 16'hC001) begin errors++; $display("FAIL rd_and_done: got %h expected c001", dataout); end
        checks++; if (pkt_waiting !== 1'b0) begin errors++; $display("FAIL rd_and_done_release: got %b expected 0", pkt_waiting); end
        read_word();
        checks++; if (dataout !== 16'hC001) begin errors++; $display("FAIL rd_empty_hold: got %h expected c001", dataout); end
        checks++; if (pkt_waiting !== 1'b0) begin errors++; $display("FAIL rd_empty_waiting: got %b expected 0", pkt_waiting); end
    endtask

    task automatic test_done_idle();
        pulse_done();
        repeat (3) cyc();
        checks++; if (pkt_waiting !== 1'b0) begin errors++; $display("FAIL idle_done_waiting: got %b expected 0", pkt_waiting); end
        checks++; if (rx_WR_enabled !== 1'b1) begin errors++; $display("FAIL idle_done_en: got %b expected 1", rx_WR_enabled); end
    endtask

    task automatic test_commit_release();
        rx_databus = 16'hD001;
        rx_WR = 1'b1;
        rx_WR_done = 1'b1;
        cyc();
        rx_WR = 1'b0;
        rx_WR_done = 1'b0;
        checks++; if (rx_WR_enabled !== 1'b0) begin errors++; $display("FAIL wrdone_pad: got %b expected 0", rx_WR_enabled); end
        repeat (254) cyc();
        checks++; if (pkt_waiting !== 1'b0) begin errors++; $display("FAIL wrdone_early: got %b expected 0", pkt_waiting); end
        cyc();
        checks++; if (pkt_waiting !== 1'b1) begin errors++; $display("FAIL wrdone_commit: got %b expected 1", pkt_waiting); end
        rx_databus = 16'hD101;
        rx_WR = 1'b1;
        rx_WR_done = 1'b1;
        cyc();
        rx_WR = 1'b0;
        rx_WR_done = 1'b0;
        repeat (254) cyc();
        RD_done = 1'b1;
        cyc();
        RD_done = 1'b0;
        checks++; if (pkt_waiting !== 1'b1) begin errors++; $display("FAIL cr_waiting: got %b expected 1", pkt_waiting); end
        checks++; if (rx_WR_enabled !== 1'b1) begin errors++; $display("FAIL cr_en: got %b expected 1", rx_WR_enabled); end
        read_word();
        checks++; if (dataout !== 16'hD101) begin errors++; $display("FAIL cr_read0: got %h expected d101", dataout); end
        read_word();
        checks++; if (dataout !== 16'h0000) begin errors++; $display("FAIL cr_read1: got %h expected 0000", dataout); end
        RD_done = 1'b1;
        cyc();
        RD_done = 1'b0;
        checks++; if (pkt_waiting !== 1'b0) begin errors++; $display("FAIL cr_release: got %b expected 0", pkt_waiting); end
    endtask

    task automatic test_reset_mid_pad();
        for (int i = 0; i < 3; i++) write_word(16'hE000 + 16'(i));
        pulse_done();
        repeat (253) cyc();
        read_word();
        checks++; if (dataout !== 16'hE000) begin errors++; $display("FAIL rmp_pre_read: got %h expected e000", dataout); end
        write_word(16'hF000);
        write_word(16'hF001);
        pulse_done();
        repeat (5) cyc();
        write_word(16'h7777);
        checks++; if (dropped_words !== 8'd1) begin errors++; $display("FAIL rmp_pad_drop: got %0d expected 1", dropped_words); end
        reset = 1'b1;
        #2;
        checks++; if (dataout !== 16'h0000) begin errors++; $display("FAIL rmp_dataout: got %h expected 0000", dataout); end
        checks++; if (pkt_waiting !== 1'b0) begin errors++; $display("FAIL rmp_waiting: got %b expected 0", pkt_waiting); end
        checks++; if (dropped_words !== 8'd0) begin errors++; $display("FAIL rmp_dropped: got %0d expected 0", dropped_words); end
        checks++; if (rx_WR_enabled !== 1'b0) begin errors++; $display("FAIL rmp_en: got %b expected 0", rx_WR_enabled); end
        cyc();
        reset = 1'b0;
        cyc();
        checks++; if (rx_WR_enabled !== 1'b1) begin errors++; $display("FAIL rmp_en_after: got %b expected 1", rx_WR_enabled); end
        write_word(16'h10F0);
        write_word(16'h10F1);
        pulse_done();
        repeat (254) cyc();
        checks++; if (pkt_waiting !== 1'b1) begin errors++; $display("FAIL rmp_new_commit: got %b expected 1", pkt_waiting); end
        read_word();
        checks++; if (dataout !== 16'h10F0) begin errors++; $display("FAIL rmp_read0: got %h expected 10f0", dataout); end
        read_word();
        checks++; if (dataout !== 16'h10F1) begin errors++; $display("FAIL rmp_read1: got %h expected 10f1", dataout); end
        read_word();
        checks++; if (dataout !== 16'h0000) begin errors++; $display("FAIL rmp_read2: got %h expected 0000", dataout); end
    endtask

    initial begin
        reset        = 1'b1;
        rx_databus   = 16'h0000;
        rx_WR        = 1'b0;
        rx_WR_done   = 1'b0;
        RD           = 1'b0;
        RD_done      = 1'b0;
        clear_status = 1'b0;
        test_reset();
        test_pad_packet();
        test_full_packet();
        test_backpressure_rd_done();
        test_done_idle();
        test_commit_release();
        test_reset_mid_pad();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cmd_resp_buffer.md
# cmd_resp_buffer

Single-clock packet buffer that receives command-response words from the in-band TX command path (`rx_databus` / `rx_WR` / `rx_WR_done`) and returns flow control on `rx_WR_enabled`. It zero-pads each response to a fixed USB packet length and holds up to `NUM_PKTS` complete packets for the RX-side USB packet reader. It sits directly downstream of the TX in-band buffer's command reader, on the `txclk` domain.

## Interface

**Parameters**
- `PKT_WORDS`, default 256: 16-bit words per packet (one 512-byte USB packet); power of two.
- `NUM_PKTS`, default 2: packet slots; power of two, ≥ 2.

**Ports**
- `txclk` input 1: clock; all logic on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `rx_databus` input 16: response word.
- `rx_WR` input 1: write strobe, one word per cycle.
- `rx_WR_done` input 1: end of current response packet.
- `rx_WR_enabled` output 1: the block can accept words.
- `pkt_waiting` output 1: at least one committed packet is held.
- `RD` input 1: read one word of the oldest packet.
- `RD_done` input 1: discard the rest of the oldest packet.
- `dataout` output 16: read word, registered.
- `clear_status` input 1: clears `dropped_words`.
- `dropped_words` output 8: saturating count of rejected writes.

## Operation

- **Storage:** RAM of `PKT_WORDS*NUM_PKTS` × 16.
  - `wr_slot`, `rd_slot`: log2(`NUM_PKTS`) bits, wrap modulo `NUM_PKTS`.
  - `wr_idx`, `rd_idx`: log2(`PKT_WORDS`)+1 bits.
  - `pkt_count`: 0..`NUM_PKTS`.
- **Write FSM states:** `W_IDLE`, `W_FILL`, `W_PAD`.
  - `W_IDLE`: on accepted `rx_WR`, write word at index 0, set `wr_idx`=1, go to `W_FILL`. `rx_WR_done` alone is ignored; no empty packets are created.
  - `W_FILL`:
    - Accepted `rx_WR` writes at `wr_idx` and increments it, provided `wr_idx` < `PKT_WORDS`.
    - If `wr_idx` == `PKT_WORDS`, the word is dropped and counted.
    - On `rx_WR_done`:
      - if `wr_idx` == `PKT_WORDS`, commit and go to `W_IDLE`;
      - otherwise go to `W_PAD`.
    - `rx_WR` together with `rx_WR_done`: the word is written first, then the done is evaluated with the updated `wr_idx`.
  - `W_PAD`: write 0x0000 at `wr_idx` each cycle and increment. The cycle that writes index `PKT_WORDS-1` commits and returns to `W_IDLE`. `rx_WR` in `W_PAD` is dropped and counted.
- **Commit:** `pkt_count`+1, `wr_slot`+1, `wr_idx`=0.
- **Accept rule:** `rx_WR_enabled` = !reset && state != `W_PAD` && `pkt_count` < `NUM_PKTS`. A slot is reserved from its first word. `rx_WR` while `rx_WR_enabled` is low is dropped and counted.
- **Read side:**
  - `pkt_waiting` = (`pkt_count` != 0).
  - `RD` with `pkt_waiting` registers RAM[`rd_slot`,`rd_idx`] into `dataout` and increments `rd_idx`.
  - After the read of index `PKT_WORDS-1`, release the slot: `pkt_count`−1, `rd_slot`+1, `rd_idx`=0.
  - `RD` with `pkt_waiting` low is ignored; `dataout` holds its value.
  - `RD_done` with `pkt_waiting` releases immediately, even with `rd_idx`=0. `RD` and `RD_done` in the same cycle: the read happens, then the release; exactly one release occurs.
- **Commit and release in the same cycle:** `pkt_count` is unchanged.
- **`dropped_words`:** +1 per dropped write, saturates at 255. `clear_status` sets it to 0 and takes priority over an increment in the same cycle.

## Timing

- Reset values: state `W_IDLE`; all pointers 0; `pkt_count` 0; `dataout` 0x0000; `pkt_waiting` 0; `dropped_words` 0; `rx_WR_enabled` 0 while `reset` is high and 1 on the first cycle after.
- Reset asserted mid-packet or mid-pad discards all buffered and partial data.
- Write side: a word is accepted in the cycle `rx_WR` is sampled high.
- Padding an n-word packet (n < `PKT_WORDS`) takes `PKT_WORDS`−n cycles after the `rx_WR_done` cycle.
- `pkt_waiting` rises the cycle after the commit edge.
- Read latency is 1: `dataout` is valid the cycle after `RD`. `pkt_waiting` falls the cycle after the releasing edge.
- `rx_WR_enabled` drops the cycle after `rx_WR_done` that enters `W_PAD`, or the cycle after the commit that fills the last slot. Upstream must sample it before every `rx_WR`.

## Test plan

- Write 0xA001..0xA004, then `rx_WR_done` → 252 pad cycles, `pkt_waiting`=1. 256 `RD`s return A001..A004 followed by 252 × 0x0000. `pkt_waiting` falls after the 256th read.
- Write exactly 256 words, then a 257th word, then `rx_WR_done` → commit with no pad cycles; `dropped_words`=1; readback is word-exact.
- Commit two packets with no reads → `rx_WR_enabled`=0. Three more `rx_WR` → `dropped_words`=3. `clear_status` → 0. One `RD_done` → `rx_WR_enabled`=1 next cycle.
- Read 10 words of packet 1, pulse `RD_done` → the next `RD` returns word 0 of packet 2; `pkt_count` decrements once.
- Pulse `rx_WR_done` in `W_IDLE` with no words → no packet, `pkt_waiting` stays 0. Separately, `rx_WR` and `rx_WR_done` in the same cycle on an empty packet → 1 data word plus 255 pad words.
- Assert `reset` mid-`W_PAD` with one committed packet held → all outputs at reset values. A following packet reads back at slot 0, index 0.
